sseg_scan_ctrl: RTL
===================

Name: sseg_scan_ctrl

Overview:
- Controller that owns the 4-digit seven-segment display and time-multiplexes it.
- Accepts 16-bit hex values plus decimal-point masks from the processing core over a valid/ready handshake.
- Holds each value in a pending buffer and commits it only at a frame boundary, so a displayed frame never mixes old and new data.
- Drives the active-low an/sseg pins directly; sits between the sequential processor and the board pins.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot (50 MHz clk -> 1 kHz digit rate); legal range 2..2^CNT_W.
- CNT_W, 16, width of the refresh counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  producer presents wr_data/wr_dp.
- wr_ready  out  1  controller can accept a word.
- wr_data  in  16  four hex nibbles; [3:0] = digit 0 (rightmost).
- wr_dp  in  4  decimal-point enables; bit i = digit i, 1 = lit.
- blank_lz  in  1  1 = blank leading zero digits (digit 0 is never blanked).
- an  out  4  digit anodes, active-low, one-hot-low.
- sseg  out  8  [7] = dp, [6:0] = g..a; all active-low.

Behaviour:
- Reset (async, any time, including mid-frame or with a word pending):
  - refresh counter = 0, digit index = 0.
  - Pending buffer empty, display register = 0x0000, dp register = 0.
  - wr_ready = 1, an = 4'b1111, sseg = 8'hFF.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = (counter == REFRESH_DIV-1).
  - On tick the digit index advances 0->1->2->3->0.
  - frame_end = tick && index == 3.
- Outputs:
  - Registered, 1-cycle latency from the index and display registers.
  - an = ~(4'b0001 << index).
  - sseg[6:0] = hex decode of the selected nibble.
  - sseg[7] = ~dp[index].
- Hex decode ({g..a}, active-low, with dp off giving the 8-bit sseg value):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Leading-zero blanking (blank_lz = 1):
  - Digit i (i = 1..3) is blanked when all nibbles from i up to 3 are zero.
  - A blanked digit has sseg[6:0] = 7'h7F.
  - dp is still honoured on a blanked digit.
  - an is still driven, so scan timing does not change.
  - blank_lz is sampled combinationally each cycle.
- Handshake:
  - Transfer occurs when wr_valid && wr_ready at a rising edge; data and dp are latched into the pending buffer and wr_ready drops the next cycle.
  - wr_ready = !pending_full.
  - The producer must hold wr_data/wr_dp stable while wr_valid && !wr_ready; values are sampled only at transfer.
- Commit:
  - On frame_end with pending_full, pending moves to the display/dp registers and pending_full clears.
  - wr_ready = 1 on the cycle after frame_end.
  - The new value appears on digit 0 starting with the output update that follows the commit edge.
- Simultaneous events:
  - A transfer cannot coincide with a commit, since wr_ready = 0 whenever pending is full.
  - A transfer on the same edge as a frame_end with pending empty is latched into pending only; it commits at the next frame_end.
- Idle: with no writes, the display keeps scanning the last committed value indefinitely.
- Worst-case latency from accept to visible is 4*REFRESH_DIV cycles plus 1.

Test Plan:
- Reset then release, REFRESH_DIV = 4:
  - During reset, an = 1111 and sseg = FF.
  - After release, an = 1110 / sseg = C0 for 4 cycles, then 1101, 1011, 0111, and back to 1110.
- Write 0x12AF with dp = 0001 and blank_lz = 0, accepted mid-frame:
  - wr_ready = 0 until frame_end.
  - Next frame shows digit 0 = 0E (F with dp), digit 1 = 88, digit 2 = A4, digit 3 = F9.
- Write 0x0070 with dp = 0000 and blank_lz = 1:
  - Digits 3 and 2 show sseg = FF while their anodes are still driven.
  - Digit 1 = F8, digit 0 = C0.
  - With blank_lz = 0, digits 3 and 2 show C0.
- Back-to-back writes 0x1111 then 0x2222, wr_valid held high:
  - The second word is accepted only the cycle after the first commit's frame_end.
  - No frame shows mixed 1s and 2s.
- Assert reset mid-frame with a word pending:
  - Pending is discarded and outputs go to 1111 / FF immediately (asynchronously).
  - After release, the display shows 0000 and wr_ready = 1.
- Write 0x0000 with dp = 1000 and blank_lz = 1:
  - Digit 3 sseg = 7F (blank segments, dp lit).
  - Digits 2 and 1 show FF.
  - Digit 0 shows C0.

Source files
------------

// File: rtl/sseg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// sseg_scan_ctrl
//   Owns a 4-digit, common-anode seven-segment display. It time-multiplexes
//   the digits and accepts new 16-bit hex values from the core over a
//   valid/ready handshake. A new value waits in a pending buffer and is
//   committed only at a frame boundary, so one frame never mixes old and
//   new data.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   wr_valid  in   producer presents wr_data / wr_dp
//   wr_ready  out  controller can accept a word (pending buffer empty)
//   wr_data   in   four hex nibbles, [3:0] = digit 0 (rightmost)
//   wr_dp     in   decimal-point enables, bit i = digit i, 1 = lit
//   blank_lz  in   1 = blank leading zero digits (digit 0 never blanked)
//   an        out  digit anodes, active-low, one-hot-low
//   sseg      out  [7] = dp, [6:0] = g..a, all active-low
// ---------------------------------------------------------------------------
module sseg_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned DATA_W   = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Pending-buffer occupancy; FULL means a word waits for the frame boundary.
  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_e;

  pend_state_e        pend_state_q, pend_state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  pend_data_q, pend_data_d;
  logic [DIGITS-1:0]  pend_dp_q, pend_dp_d;
  logic [DATA_W-1:0]  disp_q, disp_d;
  logic [DIGITS-1:0]  dp_q, dp_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;

  logic               tick;
  logic               frame_end;
  logic [3:0]         nibble;
  logic               blank;
  logic [6:0]         seg7;

  // Active-low {g..a} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Refresh counter and digit index.
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    frame_end = tick && (idx_q == IDX_LAST);
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d     = tick ? idx_q + IDX_W'(1) : idx_q;
  end

  // Pending buffer: accept while empty, commit to the display on frame_end.
  // A write landing on a frame_end while empty is only latched; it waits a
  // full frame, which keeps every frame built from a single value.
  always_comb begin
    pend_state_d = pend_state_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    disp_d       = disp_q;
    dp_d         = dp_q;
    case (pend_state_q)
      PEND_EMPTY: begin
        if (wr_valid) begin
          pend_data_d  = wr_data;
          pend_dp_d    = wr_dp;
          pend_state_d = PEND_FULL;
        end
      end
      PEND_FULL: begin
        if (frame_end) begin
          disp_d       = pend_data_q;
          dp_d         = pend_dp_q;
          pend_state_d = PEND_EMPTY;
        end
      end
      default: pend_state_d = PEND_EMPTY;
    endcase
  end

  // Digit selection, leading-zero blanking and segment decode.
  always_comb begin
    nibble = disp_q[3:0];
    blank  = 1'b0;
    case (idx_q)
      2'd0: begin
        nibble = disp_q[3:0];
        blank  = 1'b0;
      end
      2'd1: begin
        nibble = disp_q[7:4];
        blank  = (disp_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble = disp_q[11:8];
        blank  = (disp_q[15:8] == 8'h00);
      end
      2'd3: begin
        nibble = disp_q[15:12];
        blank  = (disp_q[15:12] == 4'h0);
      end
      default: begin
        nibble = disp_q[3:0];
        blank  = 1'b0;
      end
    endcase
    seg7   = (blank && blank_lz) ? 7'h7F : hex7(nibble);
    an_d   = ~(4'b0001 << idx_q);
    sseg_d = {~dp_q[idx_q], seg7};
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_state_q <= PEND_EMPTY;
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      disp_q       <= '0;
      dp_q         <= '0;
      an_q         <= 4'b1111;
      sseg_q       <= 8'hFF;
    end else begin
      pend_state_q <= pend_state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      disp_q       <= disp_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
    end
  end

  assign wr_ready = (pend_state_q == PEND_EMPTY);
  assign an       = an_q;
  assign sseg     = sseg_q;

endmodule
